cover_event_arbiter: RTL and testbench

//  Funnels cover-point hit events from NUM_REQ toggle-cover sources into one

---
 rtl/cover_event_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_cover_event_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cover_event_arbiter.sv
// cover_event_arbiter
//   Merges cover-point hit events from NUM_REQ toggle-cover sources into a
//   single valid/ready stream of cover indices for the coverage sink.
//   Each source owns a one-deep pending slot. A round-robin arbiter refills
//   a registered one-entry output slot. Lost and delivered events are counted
//   with saturating counters.
//
//   Optional feature macro: COVER_DEDUP_EN. When it is defined, a seen[]
//   bitmap suppresses repeat reports of the same cover index until reset or
//   cov_clear.
//
// Ports
//   clock        : single clock; all state updates on its rising edge
//   reset        : asynchronous, active-low
//   req_valid    : per-source hit strobe
//   req_index    : per-source cover index, source i at [i*IDX_W +: IDX_W]
//   out_valid    : out_index holds an event
//   out_ready    : sink accepts; a transfer is out_valid & out_ready
//   out_index    : reported cover index
//   cov_clear    : synchronous clear of the counters (and the seen bitmap)
//   drop_count   : events lost to overflow or out-of-range index, saturating
//   report_count : completed transfers, saturating
//   busy         : any pending slot full or output slot full
module cover_event_arbiter #(
    parameter int unsigned NUM_REQ     = 8,
    parameter int unsigned COVER_TOTAL = 8744,
    parameter int unsigned IDX_W       = 14,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]   req_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IDX_W-1:0]           out_index,
    input  logic                       cov_clear,
    output logic [CNT_W-1:0]           drop_count,
    output logic [CNT_W-1:0]           report_count,
    output logic                       busy
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned DCNT_W = $clog2(NUM_REQ + 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    slot_state_e          state_q, state_d;
    logic [IDX_W-1:0]     out_index_q, out_index_d;
    logic [NUM_REQ-1:0]   pend_q, pend_d;
    logic [IDX_W-1:0]     pend_idx_q [NUM_REQ];
    logic [IDX_W-1:0]     pend_idx_d [NUM_REQ];
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic [CNT_W-1:0]     report_q, report_d;
    logic                 busy_q, busy_d;
`ifdef COVER_DEDUP_EN
    logic [COVER_TOTAL-1:0] seen_q, seen_d;
    logic [COVER_TOTAL-1:0] seen_w;
`endif

    logic                 grant_ok;
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic                 grant;
    logic                 transfer;
    logic [DCNT_W-1:0]    drop_num;
    logic [CNT_W:0]       drop_sum;
    logic [IDX_W-1:0]     idx_i;

    // Round-robin winner: first pending source scanning upward from rr_ptr.
    always_comb begin
        grant_ok  = (state_q == S_EMPTY) || out_ready;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned c;
            c = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_found && pend_q[PTR_W'(c)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(c);
            end
        end
        grant = grant_ok && win_found;
    end

    // Output-slot FSM, pending-slot capture and statistics.
    always_comb begin
        state_d     = state_q;
        out_index_d = out_index_q;
        rr_ptr_d    = rr_ptr_q;
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        drop_num    = '0;
        drop_sum    = '0;
        idx_i       = '0;
        drop_d      = drop_q;
        report_d    = report_q;
        transfer    = (state_q == S_FULL) && out_ready;
`ifdef COVER_DEDUP_EN
        seen_w      = seen_q;
`endif

        case (state_q)
            S_EMPTY: if (grant) state_d = S_FULL;
            S_FULL: begin
                if (grant)          state_d = S_FULL;
                else if (out_ready) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase

        // Grant first so the winner's slot reads as free for a same-edge reload.
        if (grant) begin
            out_index_d     = pend_idx_q[win_idx];
            pend_d[win_idx] = 1'b0;
            rr_ptr_d        = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end

        // Ascending source order gives the lowest source priority on duplicate indices.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx_i = req_index[i*IDX_W +: IDX_W];
            if (req_valid[i]) begin
                if (32'(idx_i) >= COVER_TOTAL) begin
                    drop_num = drop_num + DCNT_W'(1);
                end
`ifdef COVER_DEDUP_EN
                else if (seen_w[idx_i]) begin
                    // repeat of an already reported index: discarded silently
                end
`endif
                else if (!pend_d[i]) begin
                    pend_d[i]     = 1'b1;
                    pend_idx_d[i] = idx_i;
`ifdef COVER_DEDUP_EN
                    seen_w[idx_i] = 1'b1;
`endif
                end else begin
                    drop_num = drop_num + DCNT_W'(1);
                end
            end
        end

        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_num);
        if (cov_clear) begin
            drop_d   = '0;
            report_d = '0;
        end else begin
            drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            if (transfer && (report_q != '1)) report_d = report_q + CNT_W'(1);
        end

`ifdef COVER_DEDUP_EN
        seen_d = cov_clear ? '0 : seen_w;
`endif
        busy_d = (|pend_d) || (state_d == S_FULL);
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            out_index_q <= '0;
            pend_q      <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) pend_idx_q[i] <= '0;
            rr_ptr_q    <= '0;
            drop_q      <= '0;
            report_q    <= '0;
            busy_q      <= 1'b0;
`ifdef COVER_DEDUP_EN
            seen_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_index_q <= out_index_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_q      <= drop_d;
            report_q    <= report_d;
            busy_q      <= busy_d;
`ifdef COVER_DEDUP_EN
            seen_q      <= seen_d;
`endif
        end
    end

    assign out_valid    = (state_q == S_FULL);
    assign out_index    = out_index_q;
    assign drop_count   = drop_q;
    assign report_count = report_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_cover_event_arbiter.sv
// Testbench for cover_event_arbiter: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural reference model.
module tb_cover_event_arbiter;

    localparam int NUM_REQ     = 8;
    localparam int COVER_TOTAL = 8744;
    localparam int IDX_W       = 14;
    localparam int CNT_W       = 32;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_index;
    logic                     cov_clear;
    logic [CNT_W-1:0]         drop_count;
    logic [CNT_W-1:0]         report_count;
    logic                     busy;

    logic [IDX_W-1:0]         ri [NUM_REQ];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    bit              m_ov;
    int unsigned     m_out;
    bit              m_pend [NUM_REQ];
    int unsigned     m_pidx [NUM_REQ];
    int unsigned     m_rr;
    longint unsigned m_drop;
    longint unsigned m_rep;
`ifdef COVER_DEDUP_EN
    bit              m_seen [COVER_TOTAL];
`endif

    cover_event_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_index    (req_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .cov_clear    (cov_clear),
        .drop_count   (drop_count),
        .report_count (report_count),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always_comb begin
        req_index = '0;
        for (int i = 0; i < NUM_REQ; i++) req_index[i*IDX_W +: IDX_W] = ri[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total += 1;
        assert (obs === exp) n_pass += 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ov = 0; m_out = 0; m_rr = 0; m_drop = 0; m_rep = 0;
        for (int i = 0; i < NUM_REQ; i++) begin m_pend[i] = 0; m_pidx[i] = 0; end
`ifdef COVER_DEDUP_EN
        for (int i = 0; i < COVER_TOTAL; i++) m_seen[i] = 0;
`endif
    endtask

    // One clock edge of the specified behaviour, using the inputs now applied.
    task automatic model_step();
        int win;
        int drops;
        bit xfer;
        win   = -1;
        drops = 0;
        xfer  = m_ov && out_ready;
        if (!m_ov || out_ready) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (win < 0 && m_pend[(m_rr + k) % NUM_REQ]) win = (m_rr + k) % NUM_REQ;
        end
        if (win >= 0) begin
            m_out = m_pidx[win];
            m_ov  = 1;
            m_pend[win] = 0;
            m_rr  = (win + 1) % NUM_REQ;
        end else if (xfer) begin
            m_ov = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (int'(ri[i]) >= COVER_TOTAL) drops++;
`ifdef COVER_DEDUP_EN
                else if (m_seen[ri[i]]) ;
`endif
                else if (!m_pend[i]) begin
                    m_pend[i] = 1;
                    m_pidx[i] = ri[i];
`ifdef COVER_DEDUP_EN
                    m_seen[ri[i]] = 1;
`endif
                end else drops++;
            end
        end
        if (cov_clear) begin
            m_drop = 0;
            m_rep  = 0;
`ifdef COVER_DEDUP_EN
            for (int i = 0; i < COVER_TOTAL; i++) m_seen[i] = 0;
`endif
        end else begin
            m_drop = (m_drop + drops > CNT_MAX) ? CNT_MAX : m_drop + drops;
            if (xfer && m_rep < CNT_MAX) m_rep++;
        end
    endtask

    function automatic bit m_busy();
        bit b;
        b = m_ov;
        for (int i = 0; i < NUM_REQ; i++) b |= m_pend[i];
        return b;
    endfunction

    task automatic check_all();
        chk("out_valid",    64'(out_valid),    64'(m_ov));
        chk("out_index",    64'(out_index),    64'(m_out));
        chk("busy",         64'(busy),         64'(m_busy()));
        chk("drop_count",   64'(drop_count),   m_drop);
        chk("report_count", 64'(report_count), m_rep);
    endtask

    // Inputs are changed only at the falling edge; outputs checked there too.
    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        cov_clear = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) ri[i] = '0;
    endtask

    task automatic clear_pulse();
        cov_clear = 1'b1;
        step();
        cov_clear = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1'b1;

        // Burst: all sources at once, delivered in source order from rr_ptr 0.
        out_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) ri[i] = IDX_W'(i);
        step();
        req_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            step();
            chk("burst_index", 64'(out_index), 64'(k));
        end
        step();
        chk("burst_busy", 64'(busy), 64'd0);
        chk("burst_drop", 64'(drop_count), 64'd0);

        // Single event: two-cycle latency.
        clear_pulse();
        req_valid = 8'b0000_1000;
        ri[3] = 14'd100;
        step();
        chk("single_c1_valid", 64'(out_valid), 64'd0);
        req_valid = '0;
        step();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_index", 64'(out_index), 64'd100);
        step();
        chk("single_report", 64'(report_count), 64'd1);
        chk("single_drop", 64'(drop_count), 64'd0);

        // Backpressure: output held, one pending reload, one overflow drop.
        out_ready = 1'b0;
        clear_pulse();
        req_valid = 8'b0000_0100;
        ri[2] = 14'd5; step();
        ri[2] = 14'd6; step();
        ri[2] = 14'd7; step();
        req_valid = '0;
        chk("bp_index", 64'(out_index), 64'd5);
        chk("bp_drop", 64'(drop_count), 64'd1);
        step();
        chk("bp_hold", 64'(out_index), 64'd5);
        out_ready = 1'b1;
        step();
        chk("bp_next", 64'(out_index), 64'd6);
        step();
        chk("bp_report", 64'(report_count), 64'd2);

        // Out-of-range index.
        clear_pulse();
        req_valid = 8'b0000_0001;
        ri[0] = 14'd9000;
        step();
        req_valid = '0;
        step();
        chk("range_valid", 64'(out_valid), 64'd0);
        chk("range_drop", 64'(drop_count), 64'd1);

        // Repeat index, then again after cov_clear.
        clear_pulse();
        req_valid = 8'b0000_0001;
        ri[0] = 14'd42;
        step();
        req_valid = '0;
        repeat (9) step();
        req_valid = 8'b0000_0001;
        step();
        req_valid = '0;
        repeat (4) step();
`ifdef COVER_DEDUP_EN
        chk("dedup_report", 64'(report_count), 64'd1);
`else
        chk("dedup_report", 64'(report_count), 64'd2);
`endif
        clear_pulse();
        req_valid = 8'b0000_0001;
        step();
        req_valid = '0;
        repeat (3) step();
        chk("dedup_after_clear", 64'(report_count), 64'd1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int r;
                req_valid[i] = ($urandom_range(0, 3) == 0);
                r = $urandom_range(0, 9);
                if (r == 0)      ri[i] = IDX_W'($urandom_range(COVER_TOTAL, (1 << IDX_W) - 1));
                else if (r == 1) ri[i] = IDX_W'(COVER_TOTAL - 1);
                else             ri[i] = IDX_W'($urandom_range(0, 63));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cov_clear = ($urandom_range(0, 49) == 0);
            step();
        end
        idle_inputs();

        // Asynchronous reset with output and pending slots occupied.
        clear_pulse();
        out_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) ri[i] = IDX_W'(200 + i);
        step();
        step();
        req_valid = '0;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_index", 64'(out_index), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_drop", 64'(drop_count), 64'd0);
        chk("reset_report", 64'(report_count), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        req_valid = 8'b0010_0000;
        ri[5] = 14'd7;
        step();
        req_valid = '0;
        step();
        chk("post_reset_index", 64'(out_index), 64'd7);
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) ri[i] = IDX_W'(300 + i);
        step();
        req_valid = '0;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
